// File: rtl/alu.sv
// alu: RV32 execute-stage integer ALU.
// Y and the flags (Zero, Neg, Carry, Ovf) are combinational from A, B and
// ALUCtrl. A registered copy of the result and flags (*_q) is captured on a
// rising clk edge whenever en is high, and held while en is low.
//
// Capture protocol: en is a plain per-cycle enable with no back-pressure.
// Every rising edge with en=1 and rst=0 loads the *_q outputs from the
// combinational outputs present at that edge. When rst is high, the *_q
// outputs are forced to the reset state regardless of en.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUCtrl,
    output logic [WIDTH-1:0] Y,
    output logic             Zero,
    output logic             Neg,
    output logic             Carry,
    output logic             Ovf,
    output logic [WIDTH-1:0] Y_q,
    output logic             Zero_q,
    output logic             Neg_q,
    output logic             Carry_q,
    output logic             Ovf_q
);

    localparam int MSB = WIDTH - 1;
    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_SLL = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_AND = 3'd5;
    localparam logic [2:0] OP_SRL = 3'd6;
    localparam logic [2:0] OP_SLT = 3'd7;

    // One extra bit on each side so the carry-out of ADD and the borrow of
    // SUB fall out of the top bit directly.
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [SHW-1:0]   shamt;
    logic             slt_bit;

    assign sum   = {1'b0, A} + {1'b0, B};
    assign diff  = {1'b0, A} - {1'b0, B};
    assign shamt = B[SHW-1:0];

    // Signed less-than. When the operand signs differ, the subtraction can
    // overflow, so the answer is simply "A is the negative one".
    assign slt_bit = (A[MSB] != B[MSB]) ? A[MSB] : diff[MSB];

    // Result and arithmetic flags; Carry and Ovf are 0 for logic ops.
    always_comb begin
        Y     = '0;
        Carry = 1'b0;
        Ovf   = 1'b0;
        case (ALUCtrl)
            OP_ADD: begin
                Y     = sum[MSB:0];
                Carry = sum[WIDTH];
                Ovf   = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
            end
            OP_SUB: begin
                Y     = diff[MSB:0];
                // No borrow out means A >= B unsigned.
                Carry = ~diff[WIDTH];
                Ovf   = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]);
            end
            OP_XOR:  Y = A ^ B;
            OP_SLL:  Y = A << shamt;
            OP_OR:   Y = A | B;
            OP_AND:  Y = A & B;
            OP_SRL:  Y = A >> shamt;
            OP_SLT:  Y = {{(WIDTH-1){1'b0}}, slt_bit};
            default: Y = '0;
        endcase
    end

    assign Zero = (Y == '0);
    assign Neg  = Y[MSB];

    // Registered copy of result and flags; reset state mirrors Y_q == 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Y_q     <= '0;
            Zero_q  <= 1'b1;
            Neg_q   <= 1'b0;
            Carry_q <= 1'b0;
            Ovf_q   <= 1'b0;
        end else if (en) begin
            Y_q     <= Y;
            Zero_q  <= Zero;
            Neg_q   <= Neg;
            Carry_q <= Carry;
            Ovf_q   <= Ovf;
        end
    end

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed-vector bench for alu with hand-computed expectations.
// Combinational outputs are sampled 1 ns after inputs change; registered
// outputs are sampled 1 ns after the rising edge.
module tb_alu;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  alu_ctrl;
    logic [31:0] y;
    logic        zero;
    logic        neg;
    logic        carry;
    logic        ovf;
    logic [31:0] y_q;
    logic        zero_q;
    logic        neg_q;
    logic        carry_q;
    logic        ovf_q;

    int n_checks = 0;
    int n_pass   = 0;

    alu #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .A       (a),
        .B       (b),
        .ALUCtrl (alu_ctrl),
        .Y       (y),
        .Zero    (zero),
        .Neg     (neg),
        .Carry   (carry),
        .Ovf     (ovf),
        .Y_q     (y_q),
        .Zero_q  (zero_q),
        .Neg_q   (neg_q),
        .Carry_q (carry_q),
        .Ovf_q   (ovf_q)
    );

    // Clock: 10 ns period, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one combinational vector and let it settle.
    task automatic drive(input logic [31:0] va, input logic [31:0] vb, input logic [2:0] op);
        a        = va;
        b        = vb;
        alu_ctrl = op;
        #1;
    endtask

    // Check all combinational outputs against hand-computed values.
    task automatic check_comb(input string tag, input logic [31:0] ey, input logic ez,
                              input logic en_, input logic ec, input logic eo);
        check({tag, ".Y"},     y,            ey);
        check({tag, ".Zero"},  {31'b0, zero},  {31'b0, ez});
        check({tag, ".Neg"},   {31'b0, neg},   {31'b0, en_});
        check({tag, ".Carry"}, {31'b0, carry}, {31'b0, ec});
        check({tag, ".Ovf"},   {31'b0, ovf},   {31'b0, eo});
    endtask

    // Check all registered outputs against hand-computed values.
    task automatic check_reg(input string tag, input logic [31:0] ey, input logic ez,
                             input logic en_, input logic ec, input logic eo);
        check({tag, ".Y_q"},     y_q,            ey);
        check({tag, ".Zero_q"},  {31'b0, zero_q},  {31'b0, ez});
        check({tag, ".Neg_q"},   {31'b0, neg_q},   {31'b0, en_});
        check({tag, ".Carry_q"}, {31'b0, carry_q}, {31'b0, ec});
        check({tag, ".Ovf_q"},   {31'b0, ovf_q},   {31'b0, eo});
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        a        = '0;
        b        = '0;
        alu_ctrl = 3'd0;
        #2;
        check_reg("reset", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        rst = 1'b0;

        // Combinational vectors: tag, expected Y, Zero, Neg, Carry, Ovf.
        drive(32'd7, 32'd5, 3'd0);              check_comb("add_7_5",    32'd12,         0, 0, 0, 0);
        drive(32'd7, 32'd7, 3'd1);              check_comb("sub_7_7",    32'd0,          1, 0, 1, 0);
        drive(32'd5, 32'd7, 3'd1);              check_comb("sub_5_7",    32'hFFFF_FFFE,  0, 1, 0, 0);
        drive(32'h8000_0000, 32'd1, 3'd1);      check_comb("sub_ovf",    32'h7FFF_FFFF,  0, 0, 1, 1);
        drive(32'd14, 32'd14, 3'd2);            check_comb("xor_eq",     32'd0,          1, 0, 0, 0);
        drive(32'd7, 32'd1, 3'd3);              check_comb("sll_1",      32'd14,         0, 0, 0, 0);
        drive(32'd7, 32'd33, 3'd3);             check_comb("sll_33",     32'd14,         0, 0, 0, 0);
        drive(32'h0000_1234, 32'd32, 3'd3);     check_comb("sll_0",      32'h0000_1234,  0, 0, 0, 0);
        drive(32'h0000_F0F0, 32'h0000_0FF0, 3'd4); check_comb("or",      32'h0000_FFF0,  0, 0, 0, 0);
        drive(32'h0000_F0F0, 32'h0000_0FF0, 3'd5); check_comb("and",     32'h0000_00F0,  0, 0, 0, 0);
        drive(32'h8000_0000, 32'd4, 3'd6);      check_comb("srl_4",      32'h0800_0000,  0, 0, 0, 0);
        drive(32'h8000_0000, 32'd31, 3'd6);     check_comb("srl_31",     32'd1,          0, 0, 0, 0);
        drive(32'h7FFF_FFFF, 32'd1, 3'd0);      check_comb("add_ovf",    32'h8000_0000,  0, 1, 0, 1);
        drive(32'hFFFF_FFFF, 32'd1, 3'd0);      check_comb("add_carry",  32'd0,          1, 0, 1, 0);
        drive(32'h8000_0000, 32'd1, 3'd7);      check_comb("slt_min_1",  32'd1,          0, 0, 0, 0);
        drive(32'h7FFF_FFFF, 32'hFFFF_FFFF, 3'd7); check_comb("slt_max_m1", 32'd0,       1, 0, 0, 0);
        drive(32'hFFFF_FFFB, 32'hFFFF_FFFE, 3'd7); check_comb("slt_neg",  32'd1,          0, 0, 0, 0);
        drive(32'd9, 32'd3, 3'd7);              check_comb("slt_pos_ge", 32'd0,          1, 0, 0, 0);

        // en stayed low through all of the above, so the register must hold.
        check_reg("hold_en0", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Register path: one capture, then hold with en low.
        @(negedge clk);
        en = 1'b1;
        drive(32'd7, 32'd5, 3'd0);
        @(posedge clk);
        #1;
        check_reg("cap_add", 32'd12, 1'b0, 1'b0, 1'b0, 1'b0);
        en = 1'b0;
        drive(32'd0, 32'd0, 3'd0);
        @(posedge clk);
        #1;
        check("hold.Y", y, 32'd0);
        check_reg("hold_12", 32'd12, 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset between edges, with en high across an edge.
        @(negedge clk);
        #2;
        en = 1'b1;
        drive(32'h7FFF_FFFF, 32'd1, 3'd0);
        rst = 1'b1;
        #1;
        check_reg("async_rst", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_reg("rst_over_en", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

        // First capture after release happens at the next rising edge.
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reg("rst_release", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_reg("cap_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);

        @(negedge clk);
        drive(32'hFFFF_FFFF, 32'd1, 3'd0);
        @(posedge clk);
        #1;
        check_reg("cap_carry", 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);

        en = 1'b0;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
